// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      write_address,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op;
  logic [4:0] rd;
  logic [31:0] a, rem, mag1, mag2, spec_res, fres, rem_n, quo_n, fin;
  logic [63:0] acc, mul_n, prod;
  logic [32:0] sum, sh;
  logic is_div, sa, sb, n1, n2, neg, neg_in, div0, ovf, fast, special, ge;
  assign is_div = funct3[2];
  assign sa = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
  assign sb = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign n1 = sa & rs1_data[31];
  assign n2 = sb & rs2_data[31];
  assign mag1 = n1 ? -rs1_data : rs1_data;
  assign mag2 = n2 ? -rs2_data : rs2_data;
  // remainder follows the dividend sign only; everything else uses the sign product
  assign neg_in = (is_div & funct3[1]) ? n1 : n1 ^ n2;
  assign div0 = is_div && rs2_data == 32'd0;
  assign ovf = is_div && !funct3[0] && rs1_data == 32'h8000_0000 && rs2_data == 32'hffff_ffff;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] ma, mb, fp;
  assign ma = 64'($signed({sa & rs1_data[31], rs1_data}));
  assign mb = 64'($signed({sb & rs2_data[31], rs2_data}));
  assign fp = ma * mb;
  assign fast = !is_div;
  assign fres = funct3[1:0] == 2'b00 ? fp[31:0] : fp[63:32];
`else
  assign fast = 1'b0;
  assign fres = 32'd0;
`endif
  assign special = div0 | ovf | fast;
  assign spec_res = fast ? fres : div0 ? (funct3[1] ? rs1_data : 32'hffff_ffff)
                                       : (funct3[1] ? 32'd0 : 32'h8000_0000);
  assign sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
  assign mul_n = {sum, acc[31:1]};
  assign sh = {rem, acc[31]};
  assign ge = sh >= {1'b0, a};
  assign rem_n = ge ? 32'(sh - {1'b0, a}) : sh[31:0];
  assign quo_n = {acc[30:0], ge};
  assign prod = neg ? -mul_n : mul_n;
  assign fin = op[2] ? (op[1] ? (neg ? -rem_n : rem_n) : (neg ? -quo_n : quo_n))
                     : (op[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? (special ? DONE : CALC) : IDLE;
      CALC: next = cnt == '1 ? DONE : CALC;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    write_enable = done && rd != 5'd0;
    write_address = rd;
    write_data = result;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      op <= 3'd0;
      rd <= 5'd0;
      a <= 32'd0;
      rem <= 32'd0;
      acc <= 64'd0;
      neg <= 1'b0;
      result <= 32'd0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      op <= funct3;
      rd <= rd_addr;
      a <= mag2;
      rem <= 32'd0;
      acc <= {32'd0, mag1};
      neg <= neg_in;
      if (special) result <= spec_res;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= op[2] ? {32'd0, quo_n} : mul_n;
      rem <= rem_n;
      if (cnt == '1) result <= fin;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit latency, results, write-back and reset abort
module tb_muldiv_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0;
  logic [4:0] rd_addr = 0;
  logic busy, done, write_enable;
  logic [31:0] result, write_data;
  logic [4:0] write_address;
  int checks = 0, errors = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n = 1, nb = 0;
    @(negedge clk);
    funct3 = f; rs1_data = x; rs2_data = y; rd_addr = rd; start = 1;
    @(negedge clk);
    start = 0; rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'd7;
    while (!done && n < 40) begin
      if (!busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " write_data"}, write_data, exp);
    chk({tag, " write_enable"}, {31'd0, write_enable}, {31'd0, rd != 5'd0});
    chk({tag, " write_address"}, {27'd0, write_address}, {27'd0, rd});
    chk({tag, " busy gaps"}, 32'(nb), 32'd0);
    @(negedge clk);
    chk({tag, " idle after"}, {30'd0, busy, done}, 32'd0);
  endtask
  initial begin
    int nd;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset flags", {29'd0, busy, done, write_enable}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset waddr", {27'd0, write_address}, 32'd0);
    run("MUL", 3'b000, 32'd7, 32'hffff_fffd, 5'd5, 32'hffff_ffeb, MUL_LAT);
    run("MULHU", 3'b011, 32'hffff_ffff, 32'hffff_ffff, 5'd6, 32'hffff_fffe, MUL_LAT);
    run("MULH", 3'b001, 32'hffff_ffff, 32'hffff_ffff, 5'd6, 32'h0000_0000, MUL_LAT);
    run("MULHSU", 3'b010, 32'hffff_ffff, 32'h0000_0002, 5'd6, 32'hffff_ffff, MUL_LAT);
    run("DIV", 3'b100, 32'hffff_fff9, 32'd2, 5'd8, 32'hffff_fffd, 33);
    run("REM", 3'b110, 32'hffff_fff9, 32'd2, 5'd8, 32'hffff_ffff, 33);
    run("DIVU", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    run("REMU", 3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 33);
    run("DIVU0", 3'b101, 32'h1234, 32'd0, 5'd10, 32'hffff_ffff, 1);
    run("REMU0", 3'b111, 32'h1234, 32'd0, 5'd10, 32'h1234, 1);
    run("DIVOVF", 3'b100, 32'h8000_0000, 32'hffff_ffff, 5'd11, 32'h8000_0000, 1);
    run("REMOVF", 3'b110, 32'h8000_0000, 32'hffff_ffff, 5'd11, 32'd0, 1);
    run("MUL x0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, MUL_LAT);
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd10; rd_addr = 5'd12; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr = 5'd13; start = 1;
    @(negedge clk);
    start = 0;
    nd = 0;
    repeat (45) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("ignored start done count", 32'(nd), 32'd1);
    chk("ignored start result", result, 32'd10);
    chk("ignored start waddr", {27'd0, write_address}, 32'd12);
    funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd14; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort flags", {29'd0, busy, done, write_enable}, 32'd0);
    chk("abort result", result, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done || write_enable) nd++;
      @(negedge clk);
    end
    chk("abort no done", 32'(nd), 32'd0);
    run("DIV after abort", 3'b100, 32'd1000, 32'd3, 5'd14, 32'd333, 33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
